// File: rtl/minmax_stream_if.sv
// minmax_stream_if: sample input stream and per-frame result stream for the min/max tracker.
// The tracker uses the slave modport; the sample source and result consumer use master.
interface minmax_stream_if #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 8
);
   logic             signed_mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_min;
   logic [WIDTH-1:0] out_max;
   logic [IDX_W-1:0] out_min_idx;
   logic [IDX_W-1:0] out_max_idx;
   logic [IDX_W-1:0] out_count;
   logic             out_ovf;
   logic             out_all_equal;
   modport slave (
      input  signed_mode, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx,
             out_count, out_ovf, out_all_equal
   );
   modport master (
      output signed_mode, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx,
             out_count, out_ovf, out_all_equal
   );
endinterface

// File: rtl/minmax_stream_tracker.sv
// minmax_stream_tracker: per-frame min/max with first-occurrence indices over a valid/ready stream.
// Signed or unsigned compare is latched on the first beat and held for the whole frame.
module minmax_stream_tracker #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 8
) (
   input logic           clk,
   input logic           rst,
   minmax_stream_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
   logic [IDX_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d, idx_q, idx_d, idx_inc;
   logic             mode_q, mode_d, ovf_q, ovf_d;
   logic             accept, lt_min, gt_max;

   // MSB decides first (inverted sense in signed mode), then the low bits as unsigned.
   function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn);
      return (a[WIDTH-1] != b[WIDTH-1]) ? (sgn ? a[WIDTH-1] : b[WIDTH-1])
                                        : (a[WIDTH-2:0] < b[WIDTH-2:0]);
   endfunction

   assign bus.in_ready      = state_q != DONE;
   assign bus.out_valid     = state_q == DONE;
   assign bus.out_min       = min_q;
   assign bus.out_max       = max_q;
   assign bus.out_min_idx   = min_idx_q;
   assign bus.out_max_idx   = max_idx_q;
   assign bus.out_count     = idx_q;
   assign bus.out_ovf       = ovf_q;
   assign bus.out_all_equal = min_q == max_q;

   assign accept  = bus.in_valid & bus.in_ready;
   assign idx_inc = (&idx_q) ? idx_q : idx_q + 1'b1;
   assign lt_min  = less(bus.in_data, min_q, mode_q);
   assign gt_max  = less(max_q, bus.in_data, mode_q);

   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      max_d     = max_q;
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;
      idx_d     = idx_q;
      mode_d    = mode_q;
      ovf_d     = ovf_q;
      if (state_q == IDLE && accept) begin
         min_d     = bus.in_data;
         max_d     = bus.in_data;
         min_idx_d = '0;
         max_idx_d = '0;
         idx_d     = '0;
         mode_d    = bus.signed_mode;
         ovf_d     = 1'b0;
         state_d   = bus.in_last ? DONE : ACCUM;
      end else if (state_q == ACCUM && accept) begin
         idx_d     = idx_inc;
         ovf_d     = ovf_q | (&idx_q);
         min_d     = lt_min ? bus.in_data : min_q;
         min_idx_d = lt_min ? idx_inc : min_idx_q;
         max_d     = gt_max ? bus.in_data : max_q;
         max_idx_d = gt_max ? idx_inc : max_idx_q;
         state_d   = bus.in_last ? DONE : ACCUM;
      end else if (state_q == DONE && bus.out_ready) begin
         state_d   = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         idx_q     <= '0;
         mode_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         max_q     <= max_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
         idx_q     <= idx_d;
         mode_q    <= mode_d;
         ovf_q     <= ovf_d;
      end
   end
endmodule

// File: tb/tb_minmax_stream_tracker.sv
// tb_minmax_stream_tracker: table vectors, hand sequences and random frames against a reference model.
// The model ranks samples as plain integers and saturates indices arithmetically.
module tb_minmax_stream_tracker;
   typedef struct packed {
      logic [7:0] mn;
      logic [7:0] mx;
      logic [3:0] mni;
      logic [3:0] mxi;
      logic [3:0] cnt;
      logic       ovf;
      logic       eq;
   } res_t;

   typedef struct {
      int   s;
      int   n;
      bit   sgn;
      int   tog;
      res_t e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   minmax_stream_if #(.WIDTH(8), .IDX_W(4)) bus ();
   minmax_stream_tracker #(.WIDTH(8), .IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int key(input logic [7:0] v, input bit sgn);
      return sgn ? int'($signed(v)) : int'(v);
   endfunction

   function automatic logic [3:0] sat(input int i);
      return (i > 15) ? 4'd15 : 4'(i);
   endfunction

   function automatic res_t model(input logic [7:0] d[$], input bit sgn);
      res_t r;
      r.mn = d[0];
      r.mx = d[0];
      r.mni = 0;
      r.mxi = 0;
      for (int i = 1; i < d.size(); i++) begin
         if (key(d[i], sgn) < key(r.mn, sgn)) begin r.mn = d[i]; r.mni = sat(i); end
         if (key(d[i], sgn) > key(r.mx, sgn)) begin r.mx = d[i]; r.mxi = sat(i); end
      end
      r.cnt = sat(d.size() - 1);
      r.ovf = d.size() > 16;
      r.eq  = r.mn == r.mx;
      return r;
   endfunction

   task automatic check_res(input string tag, input res_t e);
      chk({tag, " valid"}, bus.out_valid, 1);
      chk({tag, " min"}, bus.out_min, e.mn);
      chk({tag, " max"}, bus.out_max, e.mx);
      chk({tag, " min_idx"}, bus.out_min_idx, e.mni);
      chk({tag, " max_idx"}, bus.out_max_idx, e.mxi);
      chk({tag, " count"}, bus.out_count, e.cnt);
      chk({tag, " ovf"}, bus.out_ovf, e.ovf);
      chk({tag, " all_equal"}, bus.out_all_equal, e.eq);
   endtask

   task automatic send_beat(input logic [7:0] d, input bit last, input bit mode);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data = d;
      bus.in_last = last;
      bus.signed_mode = mode;
      while (!bus.in_ready && t < 20) begin @(posedge clk); #1; t++; end
      if (!bus.in_ready) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d[$], input bit sgn, input int tog, input bit gaps);
      for (int i = 0; i < d.size(); i++) begin
         if (gaps && $urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
         if (i > 0) chk("early_valid", bus.out_valid, 0);
         send_beat(d[i], i == d.size() - 1, (tog >= 0 && i >= tog) ? !sgn : sgn);
      end
      chk("latency", bus.out_valid, 1);
   endtask

   task automatic consume(input int hold, input res_t e);
      bus.out_ready = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         chk("hold valid", bus.out_valid, 1);
         chk("hold in_ready", bus.in_ready, 0);
         chk("hold min", bus.out_min, e.mn);
         chk("hold max", bus.out_max, e.mx);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("consumed valid", bus.out_valid, 0);
      chk("consumed in_ready", bus.in_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] pool[$];
      logic [7:0] fr[$];
      vec_t tbl[5];
      res_t e;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_last = 1'b0;
      bus.signed_mode = 1'b0;
      bus.out_ready = 1'b0;
      pool = {8'h05, 8'hFD, 8'h7F, 8'h80, 8'h00,
              8'h07, 8'h07, 8'hFF, 8'hFF,
              8'h80,
              8'h20, 8'hF0, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
              8'hE0, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h40};
      tbl[0] = '{0, 5, 1'b1, -1, '{8'h80, 8'h7F, 4'd3, 4'd2, 4'd4, 1'b0, 1'b0}};
      tbl[1] = '{0, 5, 1'b0, -1, '{8'h00, 8'hFD, 4'd4, 4'd1, 4'd4, 1'b0, 1'b0}};
      tbl[2] = '{5, 4, 1'b1, -1, '{8'hFF, 8'h07, 4'd2, 4'd0, 4'd3, 1'b0, 1'b0}};
      tbl[3] = '{9, 1, 1'b1, -1, '{8'h80, 8'h80, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1}};
      tbl[4] = '{10, 17, 1'b1, 8, '{8'hE0, 8'h40, 4'd10, 4'd15, 4'd15, 1'b1, 1'b0}};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset valid", bus.out_valid, 0);
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset min", bus.out_min, 0);
      chk("reset max", bus.out_max, 0);
      chk("reset count", bus.out_count, 0);
      chk("reset all_equal", bus.out_all_equal, 1);

      for (int v = 0; v < 5; v++) begin
         fr = {};
         for (int i = 0; i < tbl[v].n; i++) fr.push_back(pool[tbl[v].s + i]);
         send_frame(fr, tbl[v].sgn, tbl[v].tog, 1'b0);
         check_res($sformatf("vec%0d", v), tbl[v].e);
         consume(v, tbl[v].e);
      end

      send_frame({8'h11, 8'h22}, 1'b0, -1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data = 8'h33;
      bus.in_last = 1'b1;
      bus.signed_mode = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp valid", bus.out_valid, 1);
         chk("bp in_ready", bus.in_ready, 0);
         chk("bp min", bus.out_min, 8'h11);
         chk("bp max", bus.out_max, 8'h22);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp consumed valid", bus.out_valid, 0);
      chk("bp consumed in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      check_res("bp next", '{8'h33, 8'h33, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1});
      consume(0, '{8'h33, 8'h33, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1});

      send_beat(8'h01, 1'b0, 1'b1);
      send_beat(8'h02, 1'b0, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data = 8'hF0;
      #2 rst = 1'b1;
      #1;
      chk("midrst valid", bus.out_valid, 0);
      chk("midrst min", bus.out_min, 0);
      chk("midrst max", bus.out_max, 0);
      chk("midrst all_equal", bus.out_all_equal, 1);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst in_ready", bus.in_ready, 1);
      send_frame({8'h10, 8'h20}, 1'b1, -1, 1'b0);
      check_res("after rst", '{8'h10, 8'h20, 4'd0, 4'd1, 4'd1, 1'b0, 1'b0});
      consume(1, '{8'h10, 8'h20, 4'd0, 4'd1, 4'd1, 1'b0, 1'b0});

      for (int f = 0; f < 60; f++) begin
         int n;
         bit sgn;
         logic [7:0] x;
         n = $urandom_range(1, 20);
         sgn = 1'($urandom);
         fr = {};
         for (int i = 0; i < n; i++) begin
            x = 8'($urandom);
            if ($urandom_range(0, 3) == 0) x = {x[7], (x[0] ? 7'h7F : 7'h00)};
            else if ($urandom_range(0, 3) == 0) x = 8'($urandom_range(0, 3));
            fr.push_back(x);
         end
         e = model(fr, sgn);
         send_frame(fr, sgn, $urandom_range(0, 1) ? int'($urandom_range(1, 19)) : -1, 1'b1);
         check_res($sformatf("rand%0d", f), e);
         consume($urandom_range(0, 3), e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
